// File: rtl/fp_shift_arbiter.sv
// Shares one external shift_register between the FP ALU exponent-alignment and
// normalization requesters: compares, bypasses or sequences the shifter, and acks results.
module fp_shift_arbiter #(
    parameter int Mantissa_Size  = 23,
    parameter int Exponent_Size  = 8,
    parameter int Timeout_Cycles = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     align_req,
    input  logic [Mantissa_Size:0]   align_mant_a,
    input  logic [Mantissa_Size:0]   align_mant_b,
    input  logic [Exponent_Size-1:0] align_exp_a,
    input  logic [Exponent_Size-1:0] align_exp_b,
    output logic                     align_ack,
    output logic [Mantissa_Size:0]   align_mant_big,
    output logic [Mantissa_Size:0]   align_mant_small,
    output logic [Exponent_Size-1:0] align_exp,
    output logic                     align_swap,
    input  logic                     norm_req,
    input  logic [Mantissa_Size:0]   norm_mant,
    input  logic [Exponent_Size-1:0] norm_exp,
    output logic                     norm_ack,
    output logic [Mantissa_Size:0]   norm_mant_out,
    output logic [Exponent_Size-1:0] norm_exp_out,
    output logic                     norm_zero,
    output logic                     sh_enable,
    output logic                     sh_load,
    output logic                     sh_direction,
    output logic [Mantissa_Size:0]   sh_mantissa,
    output logic [Exponent_Size-1:0] sh_exponent,
    output logic [Exponent_Size-1:0] sh_no_of_shifts,
    input  logic [Mantissa_Size:0]   sh_shifted_mantissa,
    input  logic [Exponent_Size-1:0] sh_shifted_exponent,
    input  logic                     sh_done,
    output logic                     timeout_err
);
    localparam int MW  = Mantissa_Size + 1;
    localparam int EW  = Exponent_Size;
    localparam int WDW = $clog2(Timeout_Cycles + 1);
    localparam logic [EW-1:0]  MAX_SHIFT = EW'(Mantissa_Size + 1);
    localparam logic [WDW-1:0] WD_MAX    = WDW'(Timeout_Cycles);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(Timeout_Cycles - 1);
    localparam logic [WDW-1:0] WD_ARMED  = WDW'(2);

    typedef enum logic [2:0] {S_IDLE, S_CMP, S_LOAD, S_WAIT, S_RESP} state_t;
    typedef enum logic {JOB_ALIGN, JOB_NORM} job_t;

    state_t r_state, w_next;
    job_t   r_job, r_last_grant, w_grant;

    logic [MW-1:0]  r_mant_a, r_mant_b;
    logic [EW-1:0]  r_exp_a, r_exp_b;
    logic [WDW-1:0] r_wd;

    logic           r_align_ack, r_align_swap, r_norm_ack, r_norm_zero, r_timeout;
    logic [MW-1:0]  r_align_big, r_align_small, r_norm_mant;
    logic [EW-1:0]  r_align_exp, r_norm_exp;
    logic           r_sh_enable, r_sh_load, r_sh_dir;
    logic [MW-1:0]  r_sh_mant;
    logic [EW-1:0]  r_sh_exp, r_sh_cnt;

    logic           w_any, w_swap, w_done_ok, w_expired;
    logic [MW-1:0]  w_big_mant, w_small_mant;
    logic [EW-1:0]  w_big_exp, w_small_exp, w_diff;
    logic [MW-1:0]  w_res_small, w_res_norm_mant;
    logic [EW-1:0]  w_res_norm_exp, w_sh_cnt;
    logic           w_res_zero, w_timeout, w_sh_dir;

    assign w_any   = align_req | norm_req;
    // Tie goes to whichever requester was not served last.
    assign w_grant = (align_req && norm_req) ? ((r_last_grant == JOB_ALIGN) ? JOB_NORM : JOB_ALIGN)
                   : (norm_req ? JOB_NORM : JOB_ALIGN);

    assign w_swap       = r_exp_b > r_exp_a;
    assign w_big_mant   = w_swap ? r_mant_b : r_mant_a;
    assign w_small_mant = w_swap ? r_mant_a : r_mant_b;
    assign w_big_exp    = w_swap ? r_exp_b  : r_exp_a;
    assign w_small_exp  = w_swap ? r_exp_a  : r_exp_b;
    assign w_diff       = w_big_exp - w_small_exp;
    assign w_done_ok    = sh_done && (r_wd >= WD_ARMED);
    assign w_expired    = (r_wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        w_res_small     = w_small_mant;
        w_res_norm_mant = r_mant_a;
        w_res_norm_exp  = r_exp_a;
        w_res_zero      = 1'b0;
        w_timeout       = 1'b0;
        w_sh_dir        = 1'b0;
        w_sh_cnt        = '0;
        case (r_state)
            S_IDLE: if (w_any) w_next = S_CMP;
            S_CMP: begin
                if (r_job == JOB_ALIGN) begin
                    if (w_diff == '0) begin
                        w_next = S_RESP;
                    end else if (w_diff > MAX_SHIFT) begin
                        w_res_small = '0;
                        w_next      = S_RESP;
                    end else begin
                        w_sh_dir = 1'b1;
                        w_sh_cnt = w_diff;
                        w_next   = S_LOAD;
                    end
                end else if (r_mant_a == '0) begin
                    w_res_norm_mant = '0;
                    w_res_norm_exp  = '0;
                    w_res_zero      = 1'b1;
                    w_next          = S_RESP;
                end else if (r_mant_a[MW-1]) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: w_next = S_WAIT;
            S_WAIT: begin
                if (w_done_ok) begin
                    w_res_small     = sh_shifted_mantissa;
                    w_res_norm_mant = sh_shifted_mantissa;
                    w_res_norm_exp  = sh_shifted_exponent;
                    w_next          = S_RESP;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_job         <= JOB_ALIGN;
            r_last_grant  <= JOB_ALIGN;
            r_mant_a      <= '0;
            r_mant_b      <= '0;
            r_exp_a       <= '0;
            r_exp_b       <= '0;
            r_wd          <= '0;
            r_align_ack   <= 1'b0;
            r_align_big   <= '0;
            r_align_small <= '0;
            r_align_exp   <= '0;
            r_align_swap  <= 1'b0;
            r_norm_ack    <= 1'b0;
            r_norm_mant   <= '0;
            r_norm_exp    <= '0;
            r_norm_zero   <= 1'b0;
            r_timeout     <= 1'b0;
            r_sh_enable   <= 1'b0;
            r_sh_load     <= 1'b0;
            r_sh_dir      <= 1'b0;
            r_sh_mant     <= '0;
            r_sh_exp      <= '0;
            r_sh_cnt      <= '0;
        end else begin
            r_align_ack <= 1'b0;
            r_norm_ack  <= 1'b0;
            r_timeout   <= 1'b0;
            if (r_state == S_IDLE && w_any) begin
                r_job <= w_grant;
                if (w_grant == JOB_ALIGN) begin
                    r_mant_a <= align_mant_a;
                    r_mant_b <= align_mant_b;
                    r_exp_a  <= align_exp_a;
                    r_exp_b  <= align_exp_b;
                end else begin
                    r_mant_a <= norm_mant;
                    r_exp_a  <= norm_exp;
                end
            end
            if (r_state == S_CMP && w_next == S_LOAD) begin
                r_sh_dir  <= w_sh_dir;
                r_sh_cnt  <= w_sh_cnt;
                r_sh_mant <= (r_job == JOB_ALIGN) ? w_small_mant : r_mant_a;
                r_sh_exp  <= (r_job == JOB_ALIGN) ? w_small_exp  : r_exp_a;
            end
            r_sh_load   <= (w_next == S_LOAD);
            r_sh_enable <= (w_next == S_LOAD) || (w_next == S_WAIT);
            if (r_state == S_WAIT) begin
                if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end
            // Results land together with the ack so they are valid in the RESP cycle.
            if (w_next == S_RESP) begin
                r_timeout <= w_timeout;
                if (r_job == JOB_ALIGN) begin
                    r_align_ack   <= 1'b1;
                    r_align_big   <= w_big_mant;
                    r_align_small <= w_res_small;
                    r_align_exp   <= w_big_exp;
                    r_align_swap  <= w_swap;
                end else begin
                    r_norm_ack  <= 1'b1;
                    r_norm_mant <= w_res_norm_mant;
                    r_norm_exp  <= w_res_norm_exp;
                    r_norm_zero <= w_res_zero;
                end
            end
            if (r_state == S_RESP) r_last_grant <= r_job;
        end
    end

    assign align_ack        = r_align_ack;
    assign align_mant_big   = r_align_big;
    assign align_mant_small = r_align_small;
    assign align_exp        = r_align_exp;
    assign align_swap       = r_align_swap;
    assign norm_ack         = r_norm_ack;
    assign norm_mant_out    = r_norm_mant;
    assign norm_exp_out     = r_norm_exp;
    assign norm_zero        = r_norm_zero;
    assign sh_enable        = r_sh_enable;
    assign sh_load          = r_sh_load;
    assign sh_direction     = r_sh_dir;
    assign sh_mantissa      = r_sh_mant;
    assign sh_exponent      = r_sh_exp;
    assign sh_no_of_shifts  = r_sh_cnt;
    assign timeout_err      = r_timeout;
endmodule

// File: tb/tb_fp_shift_arbiter.sv
// Directed bench for fp_shift_arbiter with a behavioural shift_register model
// that can be stalled to exercise the watchdog.
module tb_fp_shift_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        align_req, norm_req;
    logic [23:0] align_mant_a, align_mant_b, norm_mant;
    logic [7:0]  align_exp_a, align_exp_b, norm_exp;
    logic        align_ack, align_swap, norm_ack, norm_zero;
    logic [23:0] align_mant_big, align_mant_small, norm_mant_out;
    logic [7:0]  align_exp, norm_exp_out;
    logic        sh_enable, sh_load, sh_direction, sh_done, timeout_err;
    logic [23:0] sh_mantissa, sh_shifted_mantissa;
    logic [7:0]  sh_exponent, sh_no_of_shifts, sh_shifted_exponent;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_shift_arbiter #(.Mantissa_Size(23), .Exponent_Size(8), .Timeout_Cycles(64)) dut (
        .clk(clk), .reset(reset),
        .align_req(align_req), .align_mant_a(align_mant_a), .align_mant_b(align_mant_b),
        .align_exp_a(align_exp_a), .align_exp_b(align_exp_b), .align_ack(align_ack),
        .align_mant_big(align_mant_big), .align_mant_small(align_mant_small),
        .align_exp(align_exp), .align_swap(align_swap),
        .norm_req(norm_req), .norm_mant(norm_mant), .norm_exp(norm_exp), .norm_ack(norm_ack),
        .norm_mant_out(norm_mant_out), .norm_exp_out(norm_exp_out), .norm_zero(norm_zero),
        .sh_enable(sh_enable), .sh_load(sh_load), .sh_direction(sh_direction),
        .sh_mantissa(sh_mantissa), .sh_exponent(sh_exponent), .sh_no_of_shifts(sh_no_of_shifts),
        .sh_shifted_mantissa(sh_shifted_mantissa), .sh_shifted_exponent(sh_shifted_exponent),
        .sh_done(sh_done), .timeout_err(timeout_err)
    );

    // Shifter model: right shift by count, or left-normalize; done pulses sh_lat+1 cycles after load.
    bit sh_hang = 1'b0;
    int sh_lat = 3;
    int m_cnt;
    bit m_pend = 1'b0;
    always @(posedge clk) begin
        logic [23:0] tm;
        logic [7:0]  te;
        sh_done <= 1'b0;
        if (reset) begin
            m_pend <= 1'b0;
        end else if (sh_load) begin
            tm = sh_mantissa;
            te = sh_exponent;
            if (sh_direction) begin
                tm = tm >> sh_no_of_shifts;
                te = te + sh_no_of_shifts;
            end else begin
                for (int k = 0; k < 24; k++)
                    if (tm != 24'h0 && !tm[23]) begin
                        tm = tm << 1;
                        te = te - 8'd1;
                    end
            end
            sh_shifted_mantissa <= tm;
            sh_shifted_exponent <= te;
            m_cnt  <= sh_lat;
            m_pend <= 1'b1;
        end else if (m_pend && !sh_hang) begin
            if (m_cnt == 0) begin
                sh_done <= 1'b1;
                m_pend  <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int          load_cnt, wait_cnt;
    logic        mon_dir;
    logic [7:0]  mon_cnt, mon_exp;
    logic [23:0] mon_mant;
    always @(negedge clk) begin
        if (sh_load) begin
            load_cnt = load_cnt + 1;
            mon_dir  = sh_direction;
            mon_cnt  = sh_no_of_shifts;
            mon_mant = sh_mantissa;
            mon_exp  = sh_exponent;
        end
        if (sh_enable && !sh_load) wait_cnt = wait_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_align(input logic [23:0] a, input logic [23:0] b, input logic [7:0] ea,
                             input logic [7:0] eb, output int lat, output bit ok);
        align_mant_a = a; align_mant_b = b; align_exp_a = ea; align_exp_b = eb;
        align_req = 1'b1; load_cnt = 0; wait_cnt = 0; lat = 0; ok = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            tick;
            if (align_ack) begin lat = i; ok = 1'b1; break; end
        end
        align_req = 1'b0;
    endtask

    task automatic run_norm(input logic [23:0] m, input logic [7:0] e, output int lat, output bit ok);
        norm_mant = m; norm_exp = e;
        norm_req = 1'b1; load_cnt = 0; wait_cnt = 0; lat = 0; ok = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            tick;
            if (norm_ack) begin lat = i; ok = 1'b1; break; end
        end
        norm_req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; align_req = 1'b0; norm_req = 1'b0;
        align_mant_a = '0; align_mant_b = '0; align_exp_a = '0; align_exp_b = '0;
        norm_mant = '0; norm_exp = '0;
        tick; tick;
        checks++;
        if ({align_ack, align_mant_big, align_mant_small, align_exp, align_swap, norm_ack,
             norm_mant_out, norm_exp_out, norm_zero, sh_enable, sh_load, sh_direction,
             sh_mantissa, sh_exponent, sh_no_of_shifts, timeout_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero, sh_enable=%b align_ack=%b norm_ack=%b",
                     sh_enable, align_ack, norm_ack);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_contention;
        logic [3:0] seq = 4'h0;
        int n = 0;
        align_mant_a = 24'hA00000; align_mant_b = 24'h900000; align_exp_a = 8'd3; align_exp_b = 8'd3;
        norm_mant = 24'h800000; norm_exp = 8'd9;
        align_req = 1'b1; norm_req = 1'b1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick;
            if (align_ack || norm_ack) begin
                seq = {seq[2:0], norm_ack};
                n++;
            end
        end
        align_req = 1'b0; norm_req = 1'b0;
        tick; tick;
        checks++;
        if (n != 4 || seq !== 4'b1010) begin
            failures++;
            $display("FAIL contention_order: got %0d acks pattern %b, expected 4 acks pattern 1010 (1=norm)", n, seq);
        end
    endtask

    task automatic test_align_shifted;
        int lat; bit ok;
        sh_lat = 3;
        run_align(24'h800000, 24'h6E2AE6, 8'd11, 8'd6, lat, ok);
        checks++;
        if (!ok || lat != 8) begin failures++; $display("FAIL align_shift_latency: got %0d ok=%b expected 8", lat, ok); end
        checks++;
        if ({align_mant_small, align_mant_big, align_exp, align_swap, timeout_err} !==
            {24'h037157, 24'h800000, 8'd11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL align_shift_result: got small=%h big=%h exp=%0d swap=%b to=%b expected 037157 800000 11 0 0",
                     align_mant_small, align_mant_big, align_exp, align_swap, timeout_err);
        end
        checks++;
        if (load_cnt != 1 || mon_dir !== 1'b1 || mon_cnt !== 8'd5 || mon_mant !== 24'h6E2AE6 || mon_exp !== 8'd6) begin
            failures++;
            $display("FAIL align_shift_ctrl: got loads=%0d dir=%b cnt=%0d mant=%h exp=%0d expected 1 1 5 6e2ae6 6",
                     load_cnt, mon_dir, mon_cnt, mon_mant, mon_exp);
        end
        tick;
        checks++;
        if (align_ack !== 1'b0 || align_mant_small !== 24'h037157) begin
            failures++;
            $display("FAIL align_ack_pulse: got ack=%b small=%h expected 0 037157", align_ack, align_mant_small);
        end
    endtask

    task automatic test_norm_shifted;
        int lat; bit ok;
        sh_lat = 3;
        run_norm(24'h062AE6, 8'd6, lat, ok);
        checks++;
        if (!ok || lat != 8 || {norm_mant_out, norm_exp_out, norm_zero} !== {24'hC55CC0, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL norm_shift_result: got ok=%b lat=%0d mant=%h exp=%0d zero=%b expected 1 8 c55cc0 1 0",
                     ok, lat, norm_mant_out, norm_exp_out, norm_zero);
        end
        checks++;
        if (load_cnt != 1 || mon_dir !== 1'b0 || mon_cnt !== 8'd0 || mon_mant !== 24'h062AE6) begin
            failures++;
            $display("FAIL norm_shift_ctrl: got loads=%0d dir=%b cnt=%0d mant=%h expected 1 0 0 062ae6",
                     load_cnt, mon_dir, mon_cnt, mon_mant);
        end
        tick;
    endtask

    task automatic test_bypass;
        int lat; bit ok;
        run_align(24'hC00000, 24'hA00000, 8'd20, 8'd20, lat, ok);
        checks++;
        if (!ok || lat != 2 || load_cnt != 0 ||
            {align_mant_big, align_mant_small, align_exp, align_swap} !== {24'hC00000, 24'hA00000, 8'd20, 1'b0}) begin
            failures++;
            $display("FAIL bypass_equal: got lat=%0d loads=%0d big=%h small=%h exp=%0d swap=%b expected 2 0 c00000 a00000 20 0",
                     lat, load_cnt, align_mant_big, align_mant_small, align_exp, align_swap);
        end
        tick;
        run_align(24'h900000, 24'hFFFFFF, 8'd5, 8'd35, lat, ok);
        checks++;
        if (!ok || lat != 2 || load_cnt != 0 ||
            {align_mant_big, align_mant_small, align_exp, align_swap} !== {24'hFFFFFF, 24'h000000, 8'd35, 1'b1}) begin
            failures++;
            $display("FAIL bypass_diff30: got lat=%0d loads=%0d big=%h small=%h exp=%0d swap=%b expected 2 0 ffffff 000000 35 1",
                     lat, load_cnt, align_mant_big, align_mant_small, align_exp, align_swap);
        end
        tick;
        run_align(24'hFFFFFF, 24'h8F0001, 8'd31, 8'd6, lat, ok);
        checks++;
        if (!ok || lat != 2 || load_cnt != 0 || align_mant_small !== 24'h0 || align_exp !== 8'd31) begin
            failures++;
            $display("FAIL bypass_diff25: got lat=%0d loads=%0d small=%h exp=%0d expected 2 0 000000 31",
                     lat, load_cnt, align_mant_small, align_exp);
        end
        tick;
        run_align(24'hFFFFFF, 24'h8F0001, 8'd30, 8'd6, lat, ok);
        checks++;
        if (!ok || load_cnt != 1 || mon_cnt !== 8'd24 || align_mant_small !== 24'h0 || align_exp !== 8'd30) begin
            failures++;
            $display("FAIL shift_diff24: got ok=%b loads=%0d cnt=%0d small=%h exp=%0d expected 1 1 24 000000 30",
                     ok, load_cnt, mon_cnt, align_mant_small, align_exp);
        end
        tick;
        run_norm(24'h000000, 8'd17, lat, ok);
        checks++;
        if (!ok || lat != 2 || load_cnt != 0 || {norm_mant_out, norm_exp_out, norm_zero} !== {24'h0, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL norm_zero: got lat=%0d loads=%0d mant=%h exp=%0d zero=%b expected 2 0 000000 0 1",
                     lat, load_cnt, norm_mant_out, norm_exp_out, norm_zero);
        end
        tick;
        run_norm(24'h800000, 8'd9, lat, ok);
        checks++;
        if (!ok || lat != 2 || load_cnt != 0 || {norm_mant_out, norm_exp_out, norm_zero} !== {24'h800000, 8'd9, 1'b0}) begin
            failures++;
            $display("FAIL norm_passthru: got lat=%0d loads=%0d mant=%h exp=%0d zero=%b expected 2 0 800000 9 0",
                     lat, load_cnt, norm_mant_out, norm_exp_out, norm_zero);
        end
        checks++;
        if (align_mant_small !== 24'h0 || align_exp !== 8'd30) begin
            failures++;
            $display("FAIL align_hold: got small=%h exp=%0d expected 000000 30", align_mant_small, align_exp);
        end
        tick;
    endtask

    task automatic test_timeout;
        int lat; bit ok;
        sh_hang = 1'b1;
        run_align(24'h800000, 24'h6E2AE6, 8'd11, 8'd6, lat, ok);
        checks++;
        if (!ok || lat != 67 || timeout_err !== 1'b1 || wait_cnt != 64) begin
            failures++;
            $display("FAIL timeout_pulse: got ok=%b lat=%0d err=%b wait_cycles=%0d expected 1 67 1 64",
                     ok, lat, timeout_err, wait_cnt);
        end
        checks++;
        if ({align_mant_big, align_mant_small, align_exp, align_swap} !== {24'h800000, 24'h6E2AE6, 8'd11, 1'b0}) begin
            failures++;
            $display("FAIL timeout_data: got big=%h small=%h exp=%0d swap=%b expected 800000 6e2ae6 11 0",
                     align_mant_big, align_mant_small, align_exp, align_swap);
        end
        tick;
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width: got %b expected 0", timeout_err); end
        sh_hang = 1'b0;
        test_norm_shifted;
    endtask

    task automatic test_reset_in_wait;
        int lat; bit ok;
        bit saw_ack = 1'b0;
        sh_hang = 1'b1;
        align_mant_a = 24'h800000; align_mant_b = 24'h6E2AE6; align_exp_a = 8'd11; align_exp_b = 8'd6;
        align_req = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        checks++;
        if (sh_enable !== 1'b1 || sh_load !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_wait: got enable=%b load=%b expected 1 0", sh_enable, sh_load);
        end
        reset = 1'b1; align_req = 1'b0;
        tick;
        reset = 1'b0;
        checks++;
        if ({align_ack, align_mant_big, align_mant_small, align_exp, align_swap, norm_ack,
             norm_mant_out, norm_exp_out, norm_zero, sh_enable, sh_load, sh_direction,
             sh_mantissa, sh_exponent, sh_no_of_shifts, timeout_err} !== '0) begin
            failures++;
            $display("FAIL reset_in_wait: some output nonzero, enable=%b big=%h norm=%h sh_mant=%h",
                     sh_enable, align_mant_big, norm_mant_out, sh_mantissa);
        end
        for (int i = 0; i < 70; i++) begin
            tick;
            if (align_ack || norm_ack || timeout_err) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack) begin failures++; $display("FAIL reset_drop_job: got ack or timeout after reset, expected none"); end
        sh_hang = 1'b0; sh_lat = 3;
        run_align(24'h6E2AE6, 24'h800000, 8'd6, 8'd11, lat, ok);
        checks++;
        if (!ok || lat != 8 || {align_mant_small, align_mant_big, align_exp, align_swap} !==
            {24'h037157, 24'h800000, 8'd11, 1'b1}) begin
            failures++;
            $display("FAIL post_reset_align: got ok=%b lat=%0d small=%h big=%h exp=%0d swap=%b expected 1 8 037157 800000 11 1",
                     ok, lat, align_mant_small, align_mant_big, align_exp, align_swap);
        end
        tick;
    endtask

    initial begin
        load_cnt = 0; wait_cnt = 0;
        test_reset;
        test_contention;
        test_align_shifted;
        test_norm_shifted;
        test_bypass;
        test_timeout;
        test_reset_in_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_shift_arbiter.md
Name: fp_shift_arbiter

Overview:
- Sequencer and arbiter that shares one shift_register instance between two requesters in the FP ALU.
- The exponent-alignment requester is the pre-add right shift of the smaller operand.
- The normalization requester is the post-add left shift until the leading 1.
- The block compares exponents, decides bypass vs. shift, drives the shifter's load/direction/count, waits for done with a watchdog, and returns results over a req/ack handshake.

Parameters:
- Mantissa_Size, 23: fraction bits; mantissa buses are Mantissa_Size+1 wide (hidden bit included).
- Exponent_Size, 8: exponent width.
- Timeout_Cycles, 64: maximum WAIT cycles for sh_done before abort.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- align_req  in  1  level request; operands held stable until align_ack.
- align_mant_a, align_mant_b  in  M+1  operand mantissas (M = Mantissa_Size).
- align_exp_a, align_exp_b  in  E  operand exponents (E = Exponent_Size).
- align_ack  out  1  one-cycle pulse; align outputs valid from this cycle.
- align_mant_big  out  M+1  mantissa of larger-exponent operand, unshifted.
- align_mant_small  out  M+1  smaller operand shifted right by the exponent difference.
- align_exp  out  E  common (larger) exponent.
- align_swap  out  1  1 when B had the strictly larger exponent.
- norm_req  in  1  level request.
- norm_mant  in  M+1  value to normalize.
- norm_exp  in  E  exponent of the value to normalize.
- norm_ack  out  1  one-cycle pulse.
- norm_mant_out  out  M+1  normalized mantissa.
- norm_exp_out  out  E  normalized exponent.
- norm_zero  out  1  input mantissa was zero.
- sh_enable, sh_load, sh_direction  out  1  shifter controls; direction 1 = right, 0 = left-normalize.
- sh_mantissa  out  M+1  shifter mantissa input.
- sh_exponent  out  E  shifter exponent input.
- sh_no_of_shifts  out  E  shifter shift count.
- sh_shifted_mantissa  in  M+1  shifter result mantissa.
- sh_shifted_exponent  in  E  shifter result exponent.
- sh_done  in  1  shifter completion.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. last_grant = ALIGN. Watchdog is cleared.
- Reset mid-operation takes effect at the next edge: any in-flight job is dropped with no ack.
- FSM states: IDLE, CMP, LOAD, WAIT, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - With a single request, grant that requester.
  - With both requests, grant the requester opposite to last_grant (round-robin), so normalization wins the first tie after reset.
  - Latch the request's operands on grant; go to CMP.
- CMP, align job:
  - big = operand with larger exponent; B counts as big only when exp_b > exp_a. Unsigned diff = big_exp − small_exp.
  - diff == 0: small passes unchanged; go to RESP (bypass).
  - diff > M+1: small = 0; go to RESP (bypass).
  - Otherwise go to LOAD with direction = 1 and no_of_shifts = diff.
- CMP, normalize job:
  - mant == 0: out = 0, exp_out = 0, norm_zero = 1; go to RESP.
  - mant[M] == 1: pass mant/exp through; go to RESP.
  - Otherwise go to LOAD with direction = 0 and no_of_shifts = 0.
- LOAD: sh_load = 1 for exactly one cycle; sh_enable = 1. Go to WAIT.
- WAIT:
  - sh_enable = 1. sh_done is ignored for the first 2 WAIT cycles, to discard stale done.
  - On sampled sh_done, capture sh_shifted_mantissa/exponent and go to RESP.
  - Align results: exponent = big exponent, not the shifter exponent.
  - Normalize results: exponent = sh_shifted_exponent.
- Watchdog: counts WAIT cycles. When it reaches Timeout_Cycles, pulse timeout_err and go to RESP with outputs = latched inputs unmodified.
- RESP:
  - Pulse ack on the granted port; the output registers update in this same cycle and hold until that port's next ack.
  - Update last_grant. Go to IDLE.
  - The requester deasserts req at the edge where ack is sampled high.
- sh_enable and sh_load are 0 in IDLE, CMP and RESP. sh_* data outputs are registered and held from LOAD through WAIT.
- Latency: bypass ack arrives in the 3rd cycle after req is sampled (IDLE→CMP→RESP). Shifted ack arrives at 3 + WAIT cycles.
- The watchdog counter is wide enough for Timeout_Cycles and saturates; it never wraps.

Test Plan:
- Align, shifted: A = 24'h800000 e = 11; B = 24'h6E2AE6 e = 6 -> sh_load one cycle, direction 1, count 5; align_ack with small = 24'h037157, big = 24'h800000, exp = 11, swap = 0.
- Normalize, shifted: norm_mant = 24'h062AE6, e = 6 -> direction 0; norm_ack with 24'hC55CC0, exp 1, norm_zero = 0.
- Bypass cases:
  - Equal exponents -> ack 3rd cycle, sh_load never asserted.
  - Exponent diff 30 -> small = 0.
  - norm_mant = 0 -> norm_zero = 1, outputs 0.
  - norm_mant = 24'h800000 -> passthrough.
- Contention: both reqs in the same cycle after reset -> norm served first, align next. Keeping both asserted must alternate grants.
- Timeout: sh_done held 0 -> timeout_err pulse after 64 WAIT cycles; ack with unmodified operands; next request served normally.
- Reset asserted in WAIT -> next cycle IDLE, all outputs 0, no ack; a subsequent align completes correctly.
